// File: rtl/de4_sopc_switch_poller.sv
// rtl/de4_sopc_switch_poller.sv - Avalon-MM switch poller with debounce and change reporting
// Polls a 16-bit switch register every POLL_PERIOD+2 cycles and publishes debounced changes.
module de4_sopc_switch_poller #(
  parameter int POLL_PERIOD  = 50000,
  parameter int STABLE_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [15:0] switches_out,
  output logic        change_valid,
  output logic [15:0] change_mask
);

  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

  localparam logic [20:0] TIMER_LAST = 21'(POLL_PERIOD - 1);
  localparam logic [3:0]  STABLE_MAX = 4'(STABLE_COUNT);

  state_t      state, state_nx;
  logic [20:0] timer, timer_nx;
  logic [15:0] sample;
  logic [15:0] candidate, candidate_nx;
  logic [3:0]  stable_cnt, stable_cnt_nx;
  logic        accept;
  logic        unused_readdata;

  assign sample          = avm_readdata[15:0];
  assign unused_readdata = ^avm_readdata[31:16];
  assign avm_address     = 2'b00;

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    avm_read = 1'b0;
    case (state)
      IDLE: begin
        if (!enable) begin
          timer_nx = '0;
        end else if (timer == TIMER_LAST) begin
          timer_nx = '0;
          state_nx = READ;
        end else begin
          timer_nx = timer + 21'd1;
        end
      end
      READ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) state_nx = WAIT;
      end
      WAIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Readdata has a fixed latency of one, so the sample is valid during WAIT.
  always_comb begin
    candidate_nx  = candidate;
    stable_cnt_nx = stable_cnt;
    accept        = 1'b0;
    if (state == WAIT) begin
      if (sample != candidate) begin
        candidate_nx  = sample;
        stable_cnt_nx = 4'd1;
      end else if (stable_cnt < STABLE_MAX) begin
        stable_cnt_nx = stable_cnt + 4'd1;
      end
      accept = (stable_cnt_nx == STABLE_MAX) && (candidate_nx != switches_out);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      timer        <= '0;
      candidate    <= '0;
      stable_cnt   <= '0;
      switches_out <= '0;
      change_valid <= 1'b0;
      change_mask  <= '0;
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      candidate    <= candidate_nx;
      stable_cnt   <= stable_cnt_nx;
      change_valid <= accept;
      if (accept) begin
        switches_out <= candidate_nx;
        change_mask  <= switches_out ^ candidate_nx;
      end
    end
  end

endmodule

// File: tb/tb_de4_sopc_switch_poller.sv
// tb/tb_de4_sopc_switch_poller.sv - randomized model-checked bench for de4_sopc_switch_poller
// Two instances (STABLE_COUNT 3 and 1) share one Avalon slave and one reference model.
module tb_de4_sopc_switch_poller;

  localparam int P  = 4;
  localparam int S0 = 3;
  localparam int S1 = 1;

  logic        clk = 1'b0;
  logic        reset_n, enable, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [1:0]  addr0, addr1;
  logic        rd0, rd1, cv0, cv1;
  logic [15:0] sw0, sw1, mask0, mask1;

  always #5 clk = ~clk;

  de4_sopc_switch_poller #(.POLL_PERIOD(P), .STABLE_COUNT(S0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .avm_address(addr0), .avm_read(rd0),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .switches_out(sw0), .change_valid(cv0), .change_mask(mask0));

  de4_sopc_switch_poller #(.POLL_PERIOD(P), .STABLE_COUNT(S1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .avm_address(addr1), .avm_read(rd1),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .switches_out(sw1), .change_valid(cv1), .change_mask(mask1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: poll schedule as counters, debounce as run length over sample history.
  int          idle_run, poll_phase, nsamples;
  logic [15:0] hist[$];
  logic [15:0] m_sw[2], m_mask[2];
  bit          m_cv[2];
  int          need[2] = '{S0, S1};

  task automatic take_sample(input logic [15:0] s);
    int run;
    hist.push_back(s);
    if (hist.size() > 16) void'(hist.pop_front());
    for (int i = 0; i < 2; i++) begin
      run = 0;
      for (int k = hist.size() - 1; k >= 0 && hist[k] == s && run < need[i]; k--) run++;
      if (run == need[i] && s != m_sw[i]) begin
        m_mask[i] = m_sw[i] ^ s;
        m_sw[i]   = s;
        m_cv[i]   = 1'b1;
      end
    end
    nsamples++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_run = 0; poll_phase = 0;
      hist.delete();
      for (int i = 0; i < 2; i++) begin m_sw[i] = '0; m_mask[i] = '0; m_cv[i] = 1'b0; end
    end else begin
      for (int i = 0; i < 2; i++) m_cv[i] = 1'b0;
      if (poll_phase == 0) begin
        if (!enable) idle_run = 0;
        else if (idle_run + 1 == P) begin idle_run = 0; poll_phase = 1; end
        else idle_run++;
      end else if (poll_phase == 1) begin
        if (!avm_waitrequest) poll_phase = 2;
      end else begin
        poll_phase = 0;
        take_sample(avm_readdata[15:0]);
      end
    end
  end

  int cyc = 0, run_len = 0, last_run = 0, pulses0 = 0, pulses1 = 0;
  bit prev_rd = 1'b0;
  int rise_q[$];

  always @(negedge clk) begin
    chk("avm_read0", rd0, poll_phase == 1);
    chk("avm_read1", rd1, poll_phase == 1);
    chk("avm_address0", addr0, 0);
    chk("avm_address1", addr1, 0);
    chk("switches_out0", sw0, m_sw[0]);
    chk("switches_out1", sw1, m_sw[1]);
    chk("change_valid0", cv0, m_cv[0]);
    chk("change_valid1", cv1, m_cv[1]);
    chk("change_mask0", mask0, m_mask[0]);
    chk("change_mask1", mask1, m_mask[1]);
    cyc++;
    if (rd0 && !prev_rd) rise_q.push_back(cyc);
    if (rd0) run_len++;
    else if (prev_rd) begin last_run = run_len; run_len = 0; end
    prev_rd = rd0;
    pulses0 += int'(cv0);
    pulses1 += int'(cv1);
  end

  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (rd0 && stall_left > 0) begin avm_waitrequest = 1'b1; stall_left--; end
    else avm_waitrequest = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sample(input string name);
    int n0, k;
    n0 = nsamples; k = 0;
    while (nsamples == n0 && k < 200) begin @(posedge clk); #1; k++; end
    if (nsamples == n0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no sample within 200 cycles", name);
    end
  endtask

  task automatic wait_read(input string name);
    int k;
    k = 0;
    while (!rd0 && k < 200) begin @(posedge clk); #1; k++; end
    chk(name, rd0, 1);
  endtask

  task automatic poll(input logic [15:0] v, input int stalls, input string name);
    logic [31:0] r;
    r = $urandom();
    avm_readdata = {r[31:16], v};
    stall_left = stalls;
    wait_sample(name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  logic [15:0] pool[5] = '{16'h00A5, 16'h0001, 16'h0000, 16'h000F, 16'h00F0};

  initial begin
    int c, p0, p1, base, prev_v, v;
    reset_n = 1'b0; enable = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0;
    tick(3);
    chk("reset_read", rd0, 0);
    chk("reset_sw", sw0, 0);
    chk("reset_cv", cv0, 0);
    chk("reset_mask", mask0, 0);
    reset_n = 1'b1;
    tick(3);
    chk("disabled_no_read", rise_q.size(), 0);

    // Timing and debounce with a constant 0xA5 slave
    avm_readdata = 32'hFFFF_00A5;
    rise_q.delete();
    c = cyc; p0 = pulses0; p1 = pulses1;
    enable = 1'b1;
    wait_sample("a5_s1");
    chk("first_read_delay", rise_q[0] - c - 1, P);
    chk("s1_cv_first", cv1, 1);
    chk("s1_sw_first", sw1, 16'h00A5);
    poll(16'h00A5, 0, "a5_s2");
    chk("s3_sw_before", sw0, 0);
    poll(16'h00A5, 0, "a5_s3");
    chk("s3_cv", cv0, 1);
    chk("s3_sw", sw0, 16'h00A5);
    chk("s3_mask", mask0, 16'h00A5);
    poll(16'h00A5, 0, "a5_s4");
    tick(2);
    chk("a5_pulses0", pulses0 - p0, 1);
    chk("a5_pulses1", pulses1 - p1, 1);
    chk("a5_read_count", rise_q.size(), 4);
    for (int i = 0; i < 3; i++) chk("a5_interval", rise_q[i + 1] - rise_q[i], 6);

    // Bounce from a freshly reset switches_out
    reset_n = 1'b0; tick(2); reset_n = 1'b1;
    p0 = pulses0; p1 = pulses1;
    poll(16'h0001, 0, "b1"); chk("b1_sw", sw0, 0);
    poll(16'h0000, 0, "b2"); chk("b2_sw", sw0, 0);
    poll(16'h0001, 0, "b3"); chk("b3_sw", sw0, 0);
    poll(16'h0001, 0, "b4"); chk("b4_sw", sw0, 0);
    poll(16'h0001, 0, "b5");
    chk("b5_sw", sw0, 16'h0001);
    chk("b5_mask", mask0, 16'h0001);
    tick(2);
    chk("bounce_pulses0", pulses0 - p0, 1);
    chk("bounce_pulses1", pulses1 - p1, 3);

    // Three-cycle stall on each read
    base = rise_q.size();
    for (int i = 0; i < 3; i++) begin
      poll(16'h1234, 3, "stall");
      chk("stall_read_len", last_run, 4);
    end
    chk("stall_interval", rise_q[base + 1] - rise_q[base], 9);
    chk("stall_sw", sw0, 16'h1234);

    // Single-sample acceptance toggling
    p1 = pulses1;
    poll(16'h000F, 0, "t1"); chk("t1_cv", cv1, 1); chk("t1_mask", mask1, 16'h1234 ^ 16'h000F);
    poll(16'h00F0, 0, "t2"); chk("t2_cv", cv1, 1); chk("t2_mask", mask1, 16'h00FF);
    poll(16'h000F, 0, "t3"); chk("t3_cv", cv1, 1);
    poll(16'h00F0, 0, "t4"); chk("t4_cv", cv1, 1);
    tick(2);
    chk("toggle_pulses1", pulses1 - p1, 4);
    chk("toggle_mask_hold", mask1, 16'h00FF);

    // Randomized polling with stalls and enable gaps
    prev_v = 0;
    for (int n = 0; n < 150; n++) begin
      v = prev_v;
      if ($urandom_range(0, 2) == 0) v = int'(pool[$urandom_range(0, 4)]);
      prev_v = v;
      if ($urandom_range(0, 5) == 0) begin
        enable = 1'b0; tick($urandom_range(1, 5)); enable = 1'b1;
      end
      poll(16'(v), $urandom_range(0, 2), "random");
    end

    // Enable dropped mid-read: the read still completes and is processed
    avm_readdata = 32'h0000_5A5A;
    tick(1);
    wait_read("drop_read_seen");
    enable = 1'b0;
    wait_sample("drop_sample");
    chk("drop_sw1", sw1, 16'h5A5A);
    base = rise_q.size();
    tick(30);
    chk("drop_no_more_reads", rise_q.size(), base);

    // Reset asserted mid-read
    enable = 1'b1;
    wait_read("rst_read_seen");
    #1 reset_n = 1'b0;
    #1;
    chk("rst_read0", rd0, 0);
    chk("rst_read1", rd1, 0);
    chk("rst_sw1", sw1, 0);
    chk("rst_cv1", cv1, 0);
    tick(2);
    reset_n = 1'b1;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
